// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: synchronised, debounced push-button that steps a 2-bit LED mode.
// Define LONG_PRESS_EN to enable long-press detection and timed auto-cycle mode.
module key_mode_ctrl #(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int AUTO_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic [1:0] ctrl,
    output logic       auto_on,
    output logic       mode_chg
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;

    logic             key_m;
    logic             key_s;
    logic             key_db;
    logic [DEB_W-1:0] deb_cnt;
    state_t           state;
    state_t           state_nxt;
    logic             short_press;
    logic             step;

    // Synchroniser and debouncer come out of reset at the released (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_m   <= 1'b1;
            key_s   <= 1'b1;
            key_db  <= 1'b1;
            deb_cnt <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            key_m <= key;
            key_s <= key_m;
            if (key_s == key_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                key_db  <= key_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int AUTO_W = $clog2(AUTO_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [AUTO_W-1:0] auto_cnt;
    logic              toggle;
    logic              auto_tick;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_nxt   = state;
        short_press = 1'b0;
        toggle      = 1'b0;
        case (state)
            IDLE:  if (!key_db) state_nxt = PRESS;
            PRESS: begin
                if (key_db) begin
                    short_press = 1'b1;
                    state_nxt   = IDLE;
                end else if (hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
                    toggle    = 1'b1;
                    state_nxt = LONG;
                end
            end
            LONG:  if (key_db) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A toggle in the same cycle as a would-be tick wins: the timer restarts instead.
    assign auto_tick = auto_on && !toggle && (auto_cnt == AUTO_W'(AUTO_CYCLES - 1));
    assign step      = short_press | auto_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            auto_cnt <= '0;
            auto_on  <= 1'b0;
        end else begin
            if (state != PRESS) hold_cnt <= '0;
            else                hold_cnt <= hold_cnt + 1'b1;

            if (toggle) auto_on <= !auto_on;

            if (!auto_on || toggle || step) auto_cnt <= '0;
            else                            auto_cnt <= auto_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        state_nxt   = state;
        short_press = 1'b0;
        case (state)
            IDLE:  if (!key_db) state_nxt = PRESS;
            PRESS: begin
                if (key_db) begin
                    short_press = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign step    = short_press;
    assign auto_on = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Manual and auto steps share one incrementer, so a coincident pair advances once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= 2'd0;
            mode_chg <= 1'b0;
        end else begin
            mode_chg <= step;
            if (step) ctrl <= ctrl + 2'd1;
        end
    end
endmodule
